// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Hazard/exception controller for a five-stage pipeline.
//            Generates stall/bubble/set_cc controls, tracks a RUN/DRAIN/
//            HALTED state, and keeps saturating cycle and retire counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_icode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       pstate,
  output logic             halted,
  output logic [2:0]       halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_POPQ   = 4'd11;
  localparam logic [3:0] RNONE    = 4'd15;
  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [2:0] S_ADR    = 3'd2;
  localparam logic [2:0] S_INS    = 3'd3;
  localparam logic [2:0] S_HLT    = 3'd4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HALTED  = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t state;

  function automatic logic exc(input logic [2:0] s);
    return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
  endfunction

  logic loaduse, retp, mispred, m_exc, w_exc;

  assign loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                   (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign retp    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mispred = (E_icode == I_JXX) && !e_Cnd;
  assign m_exc   = exc(m_stat);
  assign w_exc   = exc(W_stat);

  // Pipeline register controls; HALTED freezes fetch/decode/writeback.
  always_comb begin
    F_stall  = loaduse | retp;
    D_stall  = loaduse;
    D_bubble = mispred | (retp & ~loaduse);
    E_bubble = mispred | loaduse;
    M_bubble = m_exc | w_exc;
    W_stall  = w_exc;
    set_cc   = (E_icode == I_OPQ) & ~m_exc & ~w_exc & (state == RUN);
    if (state == HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b1;
      set_cc   = 1'b0;
    end
  end

  // Controller state machine with registered halted flag and halt status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      halted    <= 1'b0;
      halt_code <= S_AOK;
    end else begin
      case (state)
        RUN: begin
          if (w_exc) begin
            state     <= HALTED;
            halted    <= 1'b1;
            halt_code <= W_stat;
          end else if (m_exc) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_exc) begin
            state     <= HALTED;
            halted    <= 1'b1;
            halt_code <= W_stat;
          end
        end
        HALTED: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  assign pstate = state;

  // Saturating cycle and retire counters, frozen while halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else if (state != HALTED) begin
      if (cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if ((W_stat == S_AOK) && (W_icode != I_NOP) && (W_icode != I_HALT) &&
          !W_stall && (retire_cnt != '1))
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Scoreboard bench for pipe_ctrl: directed hazard/halt vectors
//            followed by random traffic, compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic e_Cnd;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic [1:0] pstate;
  logic halted;
  logic [2:0] halt_code;
  logic [CW-1:0] cycle_cnt, retire_cnt;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .pstate(pstate), .halted(halted), .halt_code(halt_code),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ctrl;   // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
    int mode;
    int hcode;
    int cyc;
    int ret;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state (mode: 0 running, 1 draining, 2 halted)
  int m_mode, m_hcode, m_cyc, m_ret;

  function automatic bit is_exc(input int s);
    return s >= 2 && s <= 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the DUT response, and advance the model.
  task automatic step(input bit r, input int di, sa, sb_, ei, edm, input bit cnd,
                      input int mi, ms, ws, wi);
    exp_t e;
    bit lu, rp, mp, fs, ds, dbb, ebb, mbb, wst, cc;
    @(posedge clk);
    #1;
    reset = r; D_icode = di[3:0]; d_srcA = sa[3:0]; d_srcB = sb_[3:0];
    E_icode = ei[3:0]; E_dstM = edm[3:0]; e_Cnd = cnd; M_icode = mi[3:0];
    m_stat = ms[2:0]; W_stat = ws[2:0]; W_icode = wi[3:0];

    lu = (ei == 5 || ei == 11) && edm != 15 && (edm == sa || edm == sb_);
    rp = (di == 9) || (ei == 9) || (mi == 9);
    mp = (ei == 7) && !cnd;
    if (m_mode == 2) begin
      fs = 1; ds = 1; dbb = 0; ebb = 0; mbb = 0; wst = 1; cc = 0;
    end else begin
      fs  = lu || rp;
      ds  = lu;
      dbb = mp || (rp && !lu);
      ebb = mp || lu;
      mbb = is_exc(ms) || is_exc(ws);
      wst = is_exc(ws);
      cc  = (ei == 6) && !is_exc(ms) && !is_exc(ws) && (m_mode == 0);
    end
    e.ctrl  = {fs, ds, dbb, ebb, mbb, wst, cc};
    e.mode  = m_mode;
    e.hcode = m_hcode;
    e.cyc   = m_cyc;
    e.ret   = m_ret;
    sb.push_back(e);

    if (r) begin
      m_mode = 0; m_hcode = 1; m_cyc = 0; m_ret = 0;
    end else if (m_mode != 2) begin
      if (m_cyc < CMAX) m_cyc++;
      if (ws == 1 && wi != 0 && wi != 1 && !wst && m_ret < CMAX) m_ret++;
      if (is_exc(ws)) begin
        m_mode = 2; m_hcode = ws;
      end else if (m_mode == 0 && is_exc(ms)) begin
        m_mode = 1;
      end
    end
  endtask

  // Quiet cycle: nothing hazardous, no exceptions, nothing retiring.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 1, 15, 1, 1, 1, 1, 1);
  endtask

  // Monitor: every output sample is checked against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("F_stall",    F_stall,    e.ctrl[6]);
        chk("D_stall",    D_stall,    e.ctrl[5]);
        chk("D_bubble",   D_bubble,   e.ctrl[4]);
        chk("E_bubble",   E_bubble,   e.ctrl[3]);
        chk("M_bubble",   M_bubble,   e.ctrl[2]);
        chk("W_stall",    W_stall,    e.ctrl[1]);
        chk("set_cc",     set_cc,     e.ctrl[0]);
        chk("pstate",     pstate,     e.mode);
        chk("halted",     halted,     (e.mode == 2));
        chk("halt_code",  halt_code,  e.hcode);
        chk("cycle_cnt",  cycle_cnt,  e.cyc);
        chk("retire_cnt", retire_cnt, e.ret);
      end
    end
  end

  initial begin
    int ms, ws, wi, rr;
    reset = 1; D_icode = 1; d_srcA = 0; d_srcB = 0; E_icode = 1; E_dstM = 15;
    e_Cnd = 1; M_icode = 1; m_stat = 1; W_stat = 1; W_icode = 1;
    repeat (2) @(posedge clk);
    m_mode = 0; m_hcode = 1; m_cyc = 0; m_ret = 0;

    // reset held, then released
    step(1, 1, 0, 0, 1, 15, 1, 1, 1, 1, 1);
    idle(2);
    // load/use hazard and its control case
    step(0, 1, 0, 3, 5, 3, 1, 1, 1, 1, 1);
    step(0, 1, 15, 0, 5, 15, 1, 1, 1, 1, 1);
    // mispredict and taken branch
    step(0, 1, 0, 0, 7, 15, 0, 1, 1, 1, 1);
    step(0, 1, 0, 0, 7, 15, 1, 1, 1, 1, 1);
    // RET combined with load/use
    step(0, 1, 2, 0, 11, 2, 1, 9, 1, 1, 1);
    // RET alone, OPQ setting condition codes, retiring instruction
    step(0, 9, 0, 0, 6, 15, 1, 1, 1, 1, 6);
    // halt sequence: memory exception, then writeback exception
    step(0, 1, 0, 0, 6, 15, 1, 1, 4, 1, 6);
    step(0, 1, 0, 0, 6, 15, 1, 1, 1, 4, 6);
    step(0, 1, 0, 3, 5, 3, 0, 9, 3, 1, 6);
    idle(3);
    // reset from HALTED
    step(1, 1, 0, 0, 1, 15, 1, 1, 1, 1, 1);
    idle(1);
    // simultaneous exceptions while running
    step(0, 1, 0, 0, 6, 15, 1, 1, 3, 2, 6);
    idle(2);
    // reset then saturation run
    step(1, 1, 0, 0, 1, 15, 1, 1, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 1, 15, 1, 1, 1, 1, 6);
    // drain state reached, then reset from DRAIN
    step(0, 1, 0, 0, 6, 15, 1, 1, 2, 1, 6);
    step(0, 1, 0, 0, 6, 15, 1, 1, 1, 1, 6);
    step(1, 1, 0, 0, 1, 15, 1, 1, 1, 1, 1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      ms = ($urandom_range(0, 29) == 0) ? $urandom_range(2, 4) :
           ($urandom_range(0, 19) == 0) ? $urandom_range(0, 7) : 1;
      ws = ($urandom_range(0, 39) == 0) ? $urandom_range(2, 4) :
           ($urandom_range(0, 19) == 0) ? $urandom_range(0, 7) : 1;
      wi = $urandom_range(0, 15);
      step(rr, $urandom_range(0, 12), $urandom_range(0, 4) | ($urandom_range(0, 7) == 0 ? 15 : 0),
           $urandom_range(0, 4), $urandom_range(0, 12),
           ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 4),
           $urandom_range(0, 1), $urandom_range(0, 12), ms, ws, wi);
    end

    begin
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
        @(negedge clk);
        budget++;
      end
      #2;
      if (sb.size() > 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
